pc_sequencer: RTL and testbench

Registered program-counter sequencer: the next generation of the combinational next-PC logic. It holds the architectural PC and presents it to instruction fetch with a valid/ready handshake. It computes the next PC (plus-4, branch, jump, register jump, exception return), takes exception entry with EPC/cause capture, detects misaligned register-jump targets, and supports halt/resume. It sits between the instruction memory port and the decode/control stage.

---
 rtl/pc_sequencer_pkg.sv | 24 ++
 rtl/pc_sequencer_if.sv | 22 ++
 rtl/pc_sequencer_npc_calc.sv | 40 ++++
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: next-PC ops, FSM states, cause codes, vectors.
// No logic; constants and types only.
// Imported by the sequencer top and its next-PC calculator.
package pc_sequencer_pkg;

    localparam logic [2:0] NPC_PLUS4  = 3'd0;
    localparam logic [2:0] NPC_BRANCH = 3'd1;
    localparam logic [2:0] NPC_JUMP   = 3'd2;
    localparam logic [2:0] NPC_JR     = 3'd3;
    localparam logic [2:0] NPC_ERET   = 3'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Address-error-on-load cause, raised for a misaligned register jump.
    localparam logic [4:0] CAUSE_ADEL = 5'd4;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_4180;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side handshake bundle: PC plus valid/ready toward instruction fetch.
// No latency; wires only.
// The consumer backpressures by holding if_ready low; the PC is held until fire.
interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] if_pc;
    logic            if_valid;
    logic            if_ready;

    modport master (
        output if_pc,
        output if_valid,
        input  if_ready
    );

    modport slave (
        input  if_pc,
        input  if_valid,
        output if_ready
    );
endinterface

// File: rtl/pc_sequencer_npc_calc.sv
// Combinational next-PC target math and register-jump alignment check.
// Zero latency; purely combinational.
// No flow control of its own; the sequencer decides when the target is taken.
module pc_sequencer_npc_calc
    import pc_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [2:0]      npc_op_i,
    input  logic            br_taken_i,
    input  logic [25:0]     imm26_i,
    input  logic [XLEN-1:0] reg_addr_i,
    input  logic [XLEN-1:0] epc_i,
    output logic [XLEN-1:0] target_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] br_off;

    assign pc4    = pc_i + XLEN'(4);
    // Branch offset is the low 16 immediate bits, word-scaled and sign-extended.
    assign br_off = {{(XLEN-18){imm26_i[15]}}, imm26_i[15:0], 2'b00};

    // Select the target for the op; unknown encodings fall back to sequential.
    always_comb begin
        target_o = pc4;
        case (npc_op_i)
            NPC_BRANCH: target_o = br_taken_i ? (pc4 + br_off) : pc4;
            NPC_JUMP:   target_o = {pc4[XLEN-1:28], imm26_i, 2'b00};
            NPC_JR:     target_o = reg_addr_i;
            NPC_ERET:   target_o = epc_i;
            default:    target_o = pc4;
        endcase
    end

    assign misalign_o = (npc_op_i == NPC_JR) && (reg_addr_i[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Registered PC sequencer: BOOT/RUN/HALT FSM, exception entry with EPC/cause capture.
// New PC visible one cycle after fire or exception; all outputs are registers.
// PC holds while if_ready is low; if_valid is high only in RUN.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0]  EXC_VECTOR   = XLEN'(DEF_EXC_VECTOR),
    parameter int               CAUSE_W      = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    pc_sequencer_if.master     fetch,
    input  logic [2:0]         npc_op,
    input  logic               br_taken,
    input  logic [25:0]        imm26,
    input  logic [XLEN-1:0]    reg_addr,
    input  logic               exc_req,
    input  logic [CAUSE_W-1:0] exc_code,
    input  logic               halt_req,
    input  logic               resume,
    output logic [XLEN-1:0]    epc,
    output logic [CAUSE_W-1:0] cause,
    output logic               in_exc,
    output logic               halted
);

    state_e             state_q;
    logic [XLEN-1:0]    pc_q;
    logic               valid_q;
    logic [XLEN-1:0]    epc_q;
    logic [CAUSE_W-1:0] cause_q;
    logic               in_exc_q;
    logic               halted_q;

    logic [XLEN-1:0]    target;
    logic               misalign;
    logic               fire;
    logic               take_exc_d;
    logic [CAUSE_W-1:0] cause_d;

    pc_sequencer_npc_calc #(.XLEN(XLEN)) u_npc_calc (
        .pc_i       (pc_q),
        .npc_op_i   (npc_op),
        .br_taken_i (br_taken),
        .imm26_i    (imm26),
        .reg_addr_i (reg_addr),
        .epc_i      (epc_q),
        .target_o   (target),
        .misalign_o (misalign)
    );

    // valid_q is only set in RUN, so fire implies RUN.
    assign fire = valid_q & fetch.if_ready;

    // External requests outrank a misaligned register jump; neither is seen in BOOT.
    assign take_exc_d = (state_q != ST_BOOT) && (exc_req || (fire && misalign));
    assign cause_d    = exc_req ? exc_code : CAUSE_W'(CAUSE_ADEL);

    // Sequencing FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_VECTOR;
            valid_q  <= 1'b0;
            epc_q    <= '0;
            cause_q  <= '0;
            in_exc_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q <= ST_RUN;
                    valid_q <= 1'b1;
                end
                ST_RUN, ST_HALT: begin
                    if (take_exc_d) begin
                        pc_q     <= EXC_VECTOR;
                        cause_q  <= cause_d;
                        in_exc_q <= 1'b1;
                        state_q  <= ST_RUN;
                        valid_q  <= 1'b1;
                        halted_q <= 1'b0;
                        // A nested exception keeps the original return address.
                        if (!in_exc_q) begin
                            epc_q <= pc_q;
                        end
                    end else if (state_q == ST_RUN && halt_req) begin
                        // The pending op is dropped; the same PC is refetched on resume.
                        state_q  <= ST_HALT;
                        valid_q  <= 1'b0;
                        halted_q <= 1'b1;
                    end else if (state_q == ST_HALT && resume) begin
                        state_q  <= ST_RUN;
                        valid_q  <= 1'b1;
                        halted_q <= 1'b0;
                    end else if (fire) begin
                        pc_q <= target;
                        if (npc_op == NPC_ERET) begin
                            in_exc_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_BOOT;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign fetch.if_pc    = pc_q;
    assign fetch.if_valid = valid_q;
    assign epc            = epc_q;
    assign cause          = cause_q;
    assign in_exc         = in_exc_q;
    assign halted         = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer: one vector per clock cycle,
// followed by a hand-written asynchronous reset sequence.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic [2:0]  npc_op;
    logic        br_taken;
    logic [25:0] imm26;
    logic [31:0] reg_addr;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic        halt_req;
    logic        resume;
    logic [31:0] epc;
    logic [4:0]  cause;
    logic        in_exc;
    logic        halted;

    int errors = 0;
    int checks = 0;

    pc_sequencer_if #(.XLEN(32)) fetch ();

    pc_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fetch    (fetch),
        .npc_op   (npc_op),
        .br_taken (br_taken),
        .imm26    (imm26),
        .reg_addr (reg_addr),
        .exc_req  (exc_req),
        .exc_code (exc_code),
        .halt_req (halt_req),
        .resume   (resume),
        .epc      (epc),
        .cause    (cause),
        .in_exc   (in_exc),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        br;
        logic [25:0] imm;
        logic [31:0] ra;
        logic        rdy;
        logic        exc;
        logic [4:0]  code;
        logic        hlt;
        logic        res;
        logic [31:0] e_pc;
        logic        e_vld;
        logic [31:0] e_epc;
        logic [4:0]  e_cause;
        logic        e_inexc;
        logic        e_halted;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [2:0] op, input logic br, input logic [25:0] imm, input logic [31:0] ra,
        input logic rdy, input logic exc, input logic [4:0] code, input logic hlt, input logic res,
        input logic [31:0] e_pc, input logic e_vld, input logic [31:0] e_epc,
        input logic [4:0] e_cause, input logic e_inexc, input logic e_halted);
        vec_t v;
        v.op = op; v.br = br; v.imm = imm; v.ra = ra; v.rdy = rdy;
        v.exc = exc; v.code = code; v.hlt = hlt; v.res = res;
        v.e_pc = e_pc; v.e_vld = e_vld; v.e_epc = e_epc;
        v.e_cause = e_cause; v.e_inexc = e_inexc; v.e_halted = e_halted;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_vld,
                             input logic [31:0] e_epc, input logic [4:0] e_cause,
                             input logic e_inexc, input logic e_halted);
        check({tag, " if_pc"},    fetch.if_pc,           e_pc);
        check({tag, " if_valid"}, 32'(fetch.if_valid),   32'(e_vld));
        check({tag, " epc"},      epc,                   e_epc);
        check({tag, " cause"},    32'(cause),            32'(e_cause));
        check({tag, " in_exc"},   32'(in_exc),           32'(e_inexc));
        check({tag, " halted"},   32'(halted),           32'(e_halted));
    endtask

    localparam logic [2:0] P4 = 3'd0, BR = 3'd1, JMP = 3'd2, JR = 3'd3, ERT = 3'd4;

    initial begin
        //                op   br  imm           ra            rdy exc code  hlt res  pc            vld epc           cause ie  h
        vecs.push_back(mk(P4,  0, 26'h0,       32'h0,        1,  0,  5'd0, 0,  0,  32'h0000_3000, 1, 32'h0,        5'd0, 0,  0)); // BOOT ignores op
        vecs.push_back(mk(P4,  0, 26'h0,       32'h0,        1,  0,  5'd0, 0,  0,  32'h0000_3004, 1, 32'h0,        5'd0, 0,  0));
        vecs.push_back(mk(P4,  0, 26'h0,       32'h0,        1,  0,  5'd0, 0,  0,  32'h0000_3008, 1, 32'h0,        5'd0, 0,  0));
        vecs.push_back(mk(P4,  0, 26'h0,       32'h0,        1,  0,  5'd0, 0,  0,  32'h0000_300C, 1, 32'h0,        5'd0, 0,  0));
        vecs.push_back(mk(P4,  0, 26'h0,       32'h0,        1,  0,  5'd0, 0,  0,  32'h0000_3010, 1, 32'h0,        5'd0, 0,  0));
        vecs.push_back(mk(BR,  1, 26'h000FFFC, 32'h0,        0,  0,  5'd0, 0,  0,  32'h0000_3010, 1, 32'h0,        5'd0, 0,  0)); // stall
        vecs.push_back(mk(BR,  1, 26'h000FFFC, 32'h0,        0,  0,  5'd0, 0,  0,  32'h0000_3010, 1, 32'h0,        5'd0, 0,  0)); // stall
        vecs.push_back(mk(BR,  1, 26'h000FFFC, 32'h0,        1,  0,  5'd0, 0,  0,  32'h0000_3004, 1, 32'h0,        5'd0, 0,  0)); // taken back
        vecs.push_back(mk(P4,  0, 26'h0,       32'h0,        1,  0,  5'd0, 0,  0,  32'h0000_3008, 1, 32'h0,        5'd0, 0,  0));
        vecs.push_back(mk(P4,  0, 26'h0,       32'h0,        1,  0,  5'd0, 0,  0,  32'h0000_300C, 1, 32'h0,        5'd0, 0,  0));
        vecs.push_back(mk(P4,  0, 26'h0,       32'h0,        1,  0,  5'd0, 0,  0,  32'h0000_3010, 1, 32'h0,        5'd0, 0,  0));
        vecs.push_back(mk(BR,  0, 26'h000FFFC, 32'h0,        1,  0,  5'd0, 0,  0,  32'h0000_3014, 1, 32'h0,        5'd0, 0,  0)); // not taken
        vecs.push_back(mk(JR,  0, 26'h0,       32'h0000_3000,1,  0,  5'd0, 0,  0,  32'h0000_3000, 1, 32'h0,        5'd0, 0,  0));
        vecs.push_back(mk(JMP, 0, 26'h0000C10, 32'h0,        1,  0,  5'd0, 0,  0,  32'h0000_3040, 1, 32'h0,        5'd0, 0,  0));
        vecs.push_back(mk(JR,  0, 26'h0,       32'h0000_3000,1,  0,  5'd0, 0,  0,  32'h0000_3000, 1, 32'h0,        5'd0, 0,  0));
        vecs.push_back(mk(JR,  0, 26'h0,       32'h0000_3101,1,  0,  5'd0, 0,  0,  32'h0000_4180, 1, 32'h0000_3000,5'd4, 1,  0)); // misalign
        vecs.push_back(mk(ERT, 0, 26'h0,       32'h0,        1,  0,  5'd0, 0,  0,  32'h0000_3000, 1, 32'h0000_3000,5'd4, 0,  0));
        vecs.push_back(mk(JR,  0, 26'h0,       32'h0000_3020,1,  0,  5'd0, 0,  0,  32'h0000_3020, 1, 32'h0000_3000,5'd4, 0,  0));
        vecs.push_back(mk(P4,  0, 26'h0,       32'h0,        0,  1,  5'd8, 0,  0,  32'h0000_4180, 1, 32'h0000_3020,5'd8, 1,  0)); // exc w/o fire
        vecs.push_back(mk(P4,  0, 26'h0,       32'h0,        1,  0,  5'd0, 0,  0,  32'h0000_4184, 1, 32'h0000_3020,5'd8, 1,  0));
        vecs.push_back(mk(P4,  0, 26'h0,       32'h0,        1,  1,  5'd5, 0,  0,  32'h0000_4180, 1, 32'h0000_3020,5'd5, 1,  0)); // nested
        vecs.push_back(mk(ERT, 0, 26'h0,       32'h0,        1,  0,  5'd0, 0,  0,  32'h0000_3020, 1, 32'h0000_3020,5'd5, 0,  0));
        vecs.push_back(mk(P4,  0, 26'h0,       32'h0,        1,  0,  5'd0, 1,  0,  32'h0000_3020, 0, 32'h0000_3020,5'd5, 0,  1)); // halt beats fire
        vecs.push_back(mk(P4,  0, 26'h0,       32'h0,        1,  0,  5'd0, 1,  0,  32'h0000_3020, 0, 32'h0000_3020,5'd5, 0,  1)); // halt in HALT
        vecs.push_back(mk(P4,  0, 26'h0,       32'h0,        1,  0,  5'd0, 0,  1,  32'h0000_3020, 1, 32'h0000_3020,5'd5, 0,  0)); // resume
        vecs.push_back(mk(P4,  0, 26'h0,       32'h0,        0,  0,  5'd0, 0,  1,  32'h0000_3020, 1, 32'h0000_3020,5'd5, 0,  0)); // resume in RUN
        vecs.push_back(mk(P4,  0, 26'h0,       32'h0,        0,  0,  5'd0, 1,  0,  32'h0000_3020, 0, 32'h0000_3020,5'd5, 0,  1));
        vecs.push_back(mk(P4,  0, 26'h0,       32'h0,        0,  1,  5'd3, 0,  0,  32'h0000_4180, 1, 32'h0000_3020,5'd3, 1,  0)); // exc in HALT
        vecs.push_back(mk(ERT, 0, 26'h0,       32'h0,        1,  0,  5'd0, 0,  0,  32'h0000_3020, 1, 32'h0000_3020,5'd3, 0,  0));
        vecs.push_back(mk(ERT, 0, 26'h0,       32'h0,        1,  0,  5'd0, 0,  0,  32'h0000_3020, 1, 32'h0000_3020,5'd3, 0,  0)); // ERET, in_exc=0
        vecs.push_back(mk(P4,  0, 26'h0,       32'h0,        1,  1,  5'd9, 1,  0,  32'h0000_4180, 1, 32'h0000_3020,5'd9, 1,  0)); // exc beats halt
        vecs.push_back(mk(JR,  0, 26'h0,       32'h0000_5002,0,  0,  5'd0, 0,  0,  32'h0000_4180, 1, 32'h0000_3020,5'd9, 1,  0)); // no fire, no trap
        vecs.push_back(mk(JR,  0, 26'h0,       32'h0000_5002,1,  0,  5'd0, 0,  0,  32'h0000_4180, 1, 32'h0000_3020,5'd4, 1,  0)); // nested misalign
        vecs.push_back(mk(JR,  0, 26'h0,       32'hFFFF_FFFC,1,  0,  5'd0, 0,  0,  32'hFFFF_FFFC, 1, 32'h0000_3020,5'd4, 1,  0));
        vecs.push_back(mk(P4,  0, 26'h0,       32'h0,        1,  0,  5'd0, 0,  0,  32'h0000_0000, 1, 32'h0000_3020,5'd4, 1,  0)); // wrap
        vecs.push_back(mk(3'd7,1, 26'h000FFFC, 32'h0,        1,  0,  5'd0, 0,  0,  32'h0000_0004, 1, 32'h0000_3020,5'd4, 1,  0)); // op 7 = PLUS4
        vecs.push_back(mk(3'd5,1, 26'h000FFFC, 32'h0,        1,  0,  5'd0, 0,  0,  32'h0000_0008, 1, 32'h0000_3020,5'd4, 1,  0)); // op 5 = PLUS4
        vecs.push_back(mk(JMP, 0, 26'h3FFFFFF, 32'h0,        1,  0,  5'd0, 0,  0,  32'h0FFF_FFFC, 1, 32'h0000_3020,5'd4, 1,  0));
        vecs.push_back(mk(P4,  0, 26'h0,       32'h0,        0,  0,  5'd0, 1,  0,  32'h0FFF_FFFC, 0, 32'h0000_3020,5'd4, 1,  1));

        rst_n = 1'b0;
        npc_op = 3'd0; br_taken = 1'b0; imm26 = '0; reg_addr = '0;
        exc_req = 1'b0; exc_code = '0; halt_req = 1'b0; resume = 1'b0;
        fetch.if_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("reset", 32'h0000_3000, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            npc_op         = vecs[i].op;
            br_taken       = vecs[i].br;
            imm26          = vecs[i].imm;
            reg_addr       = vecs[i].ra;
            fetch.if_ready = vecs[i].rdy;
            exc_req        = vecs[i].exc;
            exc_code       = vecs[i].code;
            halt_req       = vecs[i].hlt;
            resume         = vecs[i].res;
            @(posedge clk);
            #1;
            check_all($sformatf("row%0d", i), vecs[i].e_pc, vecs[i].e_vld, vecs[i].e_epc,
                      vecs[i].e_cause, vecs[i].e_inexc, vecs[i].e_halted);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a cycle, away from any clock edge.
        npc_op = 3'd0; fetch.if_ready = 1'b1; halt_req = 1'b0; exc_req = 1'b0; resume = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 32'h0000_3000, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rst_boot", 32'h0000_3000, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("post_rst_run if_pc", fetch.if_pc, 32'h0000_3004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
